// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-side trap/return controller.
//   Takes exceptions (ex_valid_i) and MRET (ret_valid_i) from the retiring
//   instruction. It owns mepc/mcause/mtval/mtvec/mstatus.{MIE,MPIE} and
//   sequences flush -> drain -> redirect.
//   Ports:
//     clk_i, rst_i (sync, active-high)
//     commit_*_i / commit_ready_o    retire handshake
//     ex_*_i, ret_valid_i            trap / MRET info for the retiring instr
//     pipeline_empty_i               upstream drained
//     flush_o, redirect_valid_o, redirect_target_o
//     csr_we_i/csr_addr_i/csr_wdata_i/csr_rdata_o   CSR port (read is combinational)
//   Optional macro TRAP_COUNT_EN adds a read-only trap counter at CSR 0x7C0.
module trap_ctrl #(
  parameter logic [31:0] RESET_VEC    = 32'h8000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        commit_valid_i,
  output logic        commit_ready_o,
  input  logic [31:0] commit_pc_i,
  input  logic        ex_valid_i,
  input  logic [3:0]  ex_code_i,
  input  logic [31:0] ex_tval_i,
  input  logic        ret_valid_i,
  input  logic        pipeline_empty_i,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_target_o,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, REDIR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0]   mtvec_q, mtvec_d, target_q, target_d;
  logic          mie_q, mie_d, mpie_q, mpie_d;
  logic          idle, trap_take, ret_take, csr_wr;

  assign idle      = (state_q == IDLE);
  assign trap_take = idle & commit_valid_i & ex_valid_i;
  assign ret_take  = idle & commit_valid_i & ret_valid_i & ~ex_valid_i;
  assign csr_wr    = idle & csr_we_i;

`ifdef TRAP_COUNT_EN
  logic [31:0] tcnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)          tcnt_q <= '0;
    else if (trap_take) tcnt_q <= tcnt_q + 32'd1;  // wraps naturally
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    mtvec_d  = mtvec_q;
    target_d = target_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;

    if (csr_wr) begin
      unique case (csr_addr_i)
        12'h300: begin mie_d = csr_wdata_i[3]; mpie_d = csr_wdata_i[7]; end
        12'h305: mtvec_d  = {csr_wdata_i[31:2], 2'b00};
        12'h341: mepc_d   = {csr_wdata_i[31:2], 2'b00};
        12'h342: mcause_d = csr_wdata_i;
        12'h343: mtval_d  = csr_wdata_i;
        default: ;
      endcase
    end

    // Trap/return updates override a same-cycle CSR write; mtvec is not
    // touched here, so an mtvec write still lands while target uses the old one.
    if (trap_take) begin
      mepc_d   = {commit_pc_i[31:2], 2'b00};
      mcause_d = {28'b0, ex_code_i};
      mtval_d  = ex_tval_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      target_d = {mtvec_q[31:2], 2'b00};
    end else if (ret_take) begin
      mie_d    = mpie_q;
      mpie_d   = 1'b1;
      target_d = mepc_q;
    end

    unique case (state_q)
      IDLE:  if (trap_take | ret_take) begin state_d = FLUSH; cnt_d = '0; end
      FLUSH: if (cnt_q == CW'(FLUSH_CYCLES - 1)) state_d = DRAIN;
             else cnt_d = cnt_q + 1'b1;
      DRAIN: if (pipeline_empty_i) state_d = REDIR;
      REDIR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      mtvec_q  <= RESET_VEC;
      target_q <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      mtvec_q  <= mtvec_d;
      target_q <= target_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
    end
  end

  // Outputs are forced quiet during the reset cycle itself.
  assign commit_ready_o    = ~rst_i & idle;
  assign flush_o           = ~rst_i & (state_q == FLUSH);
  assign redirect_valid_o  = ~rst_i & (state_q == REDIR);
  assign redirect_target_o = rst_i ? 32'h0 : target_q;

  always_comb begin
    csr_rdata_o = '0;
    unique case (csr_addr_i)
      12'h300: csr_rdata_o = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
      12'h305: csr_rdata_o = mtvec_q;
      12'h341: csr_rdata_o = mepc_q;
      12'h342: csr_rdata_o = mcause_q;
      12'h343: csr_rdata_o = mtval_q;
`ifdef TRAP_COUNT_EN
      12'h7C0: csr_rdata_o = tcnt_q;
`endif
      default: csr_rdata_o = '0;
    endcase
  end
endmodule
